// File: rtl/typedefs_pkg.sv
// typedefs_pkg: shared ALU operation select encoding.
package typedefs_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } aluop_sel_t;
endpackage

// File: rtl/alu_op_seq_if.sv
// alu_op_seq_if: request/response handshake plus register bank and ALU ports of the sequencer.
interface alu_op_seq_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  typedefs_pkg::aluop_sel_t req_op;
  logic [AWIDTH-1:0]        req_rs1;
  logic [AWIDTH-1:0]        req_rs2;
  logic [AWIDTH-1:0]        req_rd;
  logic                     req_use_imm;
  logic [DWIDTH-1:0]        req_imm;
  logic [AWIDTH-1:0]        rf_raddr1;
  logic [AWIDTH-1:0]        rf_raddr2;
  logic [DWIDTH-1:0]        rf_rdata1;
  logic [DWIDTH-1:0]        rf_rdata2;
  logic [AWIDTH-1:0]        rf_waddr;
  logic [DWIDTH-1:0]        rf_wdata;
  logic                     rf_wen;
  logic [DWIDTH-1:0]        alu_src1;
  logic [DWIDTH-1:0]        alu_src2;
  typedefs_pkg::aluop_sel_t alu_sel;
  logic [DWIDTH-1:0]        alu_res;
  logic                     alu_res_is_0;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DWIDTH-1:0]        rsp_res;
  logic                     rsp_zero;
  logic [AWIDTH-1:0]        rsp_rd;
  modport master (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_use_imm, req_imm,
    input  rf_rdata1, rf_rdata2, alu_res, alu_res_is_0, rsp_ready,
    output req_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen,
    output alu_src1, alu_src2, alu_sel, rsp_valid, rsp_res, rsp_zero, rsp_rd
  );
  modport slave (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, req_use_imm, req_imm,
    output rf_rdata1, rf_rdata2, alu_res, alu_res_is_0, rsp_ready,
    input  req_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen,
    input  alu_src1, alu_src2, alu_sel, rsp_valid, rsp_res, rsp_zero, rsp_rd
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: read -> execute -> writeback -> respond driver for register_bank and alu.
// Defining ALU_OP_SEQ_FAST_EN merges READ into EXEC (3-cycle latency instead of 4).
module alu_op_sequencer
  import typedefs_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_op_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;
`ifdef ALU_OP_SEQ_FAST_EN
  localparam state_t FIRST = EXEC;
`else
  localparam state_t FIRST = READ;
  logic [DWIDTH-1:0] op1, op2;
`endif
  state_t            state, nxt;
  aluop_sel_t        op;
  logic [AWIDTH-1:0] rs1, rs2, rd;
  logic              use_imm, zero;
  logic [DWIDTH-1:0] imm, result, src1, src2;
  logic              in_read, in_exec, in_wb, in_resp;

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_comb
    nxt = state == IDLE ? (bus.req_valid ? FIRST : IDLE) :
          state == READ ? EXEC :
          state == EXEC ? WB :
          state == WB   ? RESP :
          (state == RESP && !bus.rsp_ready) ? RESP : IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= ALU_ADD;
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      use_imm <= 1'b0;
      imm     <= '0;
      result  <= '0;
      zero    <= 1'b0;
`ifndef ALU_OP_SEQ_FAST_EN
      op1     <= '0;
      op2     <= '0;
`endif
    end else begin
      if (state == IDLE && bus.req_valid) begin
        op      <= bus.req_op;
        rs1     <= bus.req_rs1;
        rs2     <= bus.req_rs2;
        rd      <= bus.req_rd;
        use_imm <= bus.req_use_imm;
        imm     <= bus.req_imm;
      end
`ifndef ALU_OP_SEQ_FAST_EN
      if (state == READ) begin
        op1 <= bus.rf_rdata1;
        op2 <= use_imm ? imm : bus.rf_rdata2;
      end
`endif
      if (state == EXEC) begin
        result <= bus.alu_res;
        zero   <= bus.alu_res_is_0;
      end
    end
  end

  // Every output is forced low while rst is high, whatever state is held.
  always_comb begin
    in_exec = !rst && state == EXEC;
    in_wb   = !rst && state == WB;
    in_resp = !rst && state == RESP;
`ifdef ALU_OP_SEQ_FAST_EN
    in_read = in_exec;
    src1    = bus.rf_rdata1;
    src2    = use_imm ? imm : bus.rf_rdata2;
`else
    in_read = !rst && state == READ;
    src1    = op1;
    src2    = op2;
`endif
    bus.req_ready = !rst && state == IDLE;
    bus.rf_raddr1 = in_read ? rs1 : '0;
    bus.rf_raddr2 = in_read ? rs2 : '0;
    bus.alu_src1  = in_exec ? src1 : '0;
    bus.alu_src2  = in_exec ? src2 : '0;
    bus.alu_sel   = in_exec ? op : ALU_ADD;
    bus.rf_waddr  = in_wb ? rd : '0;
    bus.rf_wdata  = in_wb ? result : '0;
    bus.rf_wen    = in_wb && rd != '0;
    bus.rsp_valid = in_resp;
    bus.rsp_res   = in_resp ? result : '0;
    bus.rsp_zero  = in_resp && zero;
    bus.rsp_rd    = in_resp ? rd : '0;
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: sequencer driving a behavioural register bank and ALU, checked cycle by cycle
// against a transaction-level model (queue of accepted ops, expected phase timing from accept cycle).
module tb_alu_op_sequencer;
  import typedefs_pkg::*;
`ifdef ALU_OP_SEQ_FAST_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_seq_if #(.AWIDTH(3), .DWIDTH(32)) bus ();
  alu_op_sequencer #(.AWIDTH(3), .DWIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] bank [8] = '{default: '0};
  logic [31:0] ref_regs [8] = '{default: '0};

  function automatic logic [31:0] alu_f(input aluop_sel_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $signed(a) >>> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign bus.rf_rdata1    = bank[bus.rf_raddr1];
  assign bus.rf_rdata2    = bank[bus.rf_raddr2];
  assign bus.alu_res      = alu_f(bus.alu_sel, bus.alu_src1, bus.alu_src2);
  assign bus.alu_res_is_0 = bus.alu_res == 32'h0;
  always @(posedge clk) if (bus.rf_wen && bus.rf_waddr != 3'd0) bank[bus.rf_waddr] <= bus.rf_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int acc;
    logic [2:0] rs1, rs2, rd;
    aluop_sel_t op;
    logic [31:0] s1, s2, res;
  } ent_t;
  ent_t q[$];

  always @(negedge clk) begin : model
    ent_t h, n;
    bit has, e_read, e_exec, e_wb, e_valid, ok;
    cyc++;
    has = q.size() > 0;
    if (has) h = q[0];
    e_read  = !rst && has && cyc == h.acc + 1;
    e_exec  = !rst && has && cyc == h.acc + LAT - 2;
    e_wb    = !rst && has && cyc == h.acc + LAT - 1;
    e_valid = !rst && has && cyc >= h.acc + LAT;
    chk("req_ready", bus.req_ready, !rst && !has);
    chk("rf_raddr1", bus.rf_raddr1, e_read ? h.rs1 : 3'd0);
    chk("rf_raddr2", bus.rf_raddr2, e_read ? h.rs2 : 3'd0);
    chk("alu_sel", bus.alu_sel, e_exec ? h.op : ALU_ADD);
    chk("alu_src1", bus.alu_src1, e_exec ? h.s1 : 32'h0);
    chk("alu_src2", bus.alu_src2, e_exec ? h.s2 : 32'h0);
    chk("rf_wen", bus.rf_wen, e_wb && h.rd != 3'd0);
    chk("rf_waddr", bus.rf_waddr, e_wb ? h.rd : 3'd0);
    chk("rf_wdata", bus.rf_wdata, e_wb ? h.res : 32'h0);
    chk("rsp_valid", bus.rsp_valid, e_valid);
    if (e_valid) begin
      chk("rsp_res", bus.rsp_res, h.res);
      chk("rsp_zero", bus.rsp_zero, h.res == 32'h0);
      chk("rsp_rd", bus.rsp_rd, h.rd);
    end else if (rst) begin
      chk("rst_rsp_res", bus.rsp_res, 32'h0);
      chk("rst_rsp_zero", bus.rsp_zero, 0);
      chk("rst_rsp_rd", bus.rsp_rd, 3'd0);
    end
    ok = 1;
    for (int i = 0; i < 8; i++) if (bank[i] !== ref_regs[i]) ok = 0;
    chk("regfile", ok, 1);
    if (rst) q.delete();
    else begin
      if (e_wb && h.rd != 3'd0) ref_regs[h.rd] = h.res;
      if (e_valid && bus.rsp_ready) void'(q.pop_front());
      if (!has && bus.req_valid) begin
        n.acc = cyc;
        n.rs1 = bus.req_rs1;
        n.rs2 = bus.req_rs2;
        n.rd  = bus.req_rd;
        n.op  = bus.req_op;
        n.s1  = ref_regs[bus.req_rs1];
        n.s2  = bus.req_use_imm ? bus.req_imm : ref_regs[bus.req_rs2];
        n.res = alu_f(n.op, n.s1, n.s2);
        q.push_back(n);
      end
    end
  end

  // Called just after a rising edge; returns just after the response handshake edge.
  task automatic do_op(input aluop_sel_t op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                       input logic u, input logic [31:0] im, input bit rr, input int hold,
                       output logic [31:0] res, output logic z, output int lat);
    int n = 0;
    bus.req_op = op;
    bus.req_rs1 = a;
    bus.req_rs2 = b;
    bus.req_rd = d;
    bus.req_use_imm = u;
    bus.req_imm = im;
    bus.req_valid = 1'b1;
    bus.rsp_ready = rr;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
    chk("accept", bus.req_ready, 1);
    @(posedge clk);
    #2 bus.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 20);
    chk("rsp_seen", bus.rsp_valid, 1);
    res = bus.rsp_res;
    z = bus.rsp_zero;
    if (!rr) begin
      repeat (hold) @(negedge clk);
      chk("held_valid", bus.rsp_valid, 1);
      @(posedge clk);
      #2 bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #2 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, r1;
    logic z;
    int lat;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_op = ALU_ADD;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_rd = '0;
    bus.req_use_imm = 1'b0;
    bus.req_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1);
    @(posedge clk);
    #2;
    do_op(ALU_ADD, 0, 0, 1, 1, 32'h5, 1, 0, r, z, lat);
    do_op(ALU_ADD, 0, 0, 2, 1, 32'h3, 1, 0, r, z, lat);
    do_op(ALU_ADD, 0, 0, 5, 1, 32'h8000_0000, 1, 0, r, z, lat);
    do_op(ALU_ADD, 0, 0, 4, 1, 32'h7, 1, 0, r, z, lat);
    do_op(ALU_ADD, 1, 2, 3, 0, 32'h0, 0, 0, r, z, lat);
    chk("add_latency", lat, LAT);
    chk("add_res", r, 32'h8);
    chk("add_zero", z, 0);
    chk("add_reg3", bank[3], 32'h8);
    do_op(ALU_ADD, 0, 0, 1, 1, 32'h1234, 1, 0, r, z, lat);
    do_op(ALU_SUB, 1, 1, 4, 0, 32'h0, 0, 0, r, z, lat);
    chk("sub_res", r, 32'h0);
    chk("sub_zero", z, 1);
    chk("sub_reg4", bank[4], 32'h0);
    do_op(ALU_SRA, 5, 0, 0, 1, 32'h4, 0, 0, r, z, lat);
    chk("sra_res", r, 32'hF800_0000);
    chk("sra_reg0", bank[0], 32'h0);
    do_op(ALU_ADD, 1, 2, 6, 0, 32'h0, 1, 0, r1, z, lat);
    do_op(ALU_ADD, 6, 0, 7, 1, 32'h1, 1, 0, r, z, lat);
    chk("b2b_first", r1, 32'h1237);
    chk("b2b_raw", r, 32'h1238);
    chk("b2b_latency", lat, LAT);
    do_op(ALU_XOR, 1, 2, 3, 0, 32'h0, 0, 10, r, z, lat);
    chk("stall_res", r, 32'h1237);
    bus.req_op = ALU_ADD;
    bus.req_rs1 = 3'd0;
    bus.req_rd = 3'd3;
    bus.req_use_imm = 1'b1;
    bus.req_imm = 32'h55;
    bus.req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 bus.req_valid = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_wb_wen", bus.rf_wen, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_ready", bus.req_ready, 1);
    chk("rst_wb_reg3", bank[3], 32'h1237);
    @(posedge clk);
    #2;
    for (int i = 0; i < 60; i++)
      do_op(aluop_sel_t'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), r, z, lat);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1);
  end
endmodule
